// File: rtl/mznm_pkg.sv
// Shared fetch-side types and constants for the mznm core.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
//
// Contents:
//   INSTR_W, PC_W   instruction word and program-counter widths
//   NOP_INSTR       word placed in the IF/ID opcode slot on reset/flush
//   fetch_state_t   fetch FSM: S_WORD0 (expect opcode word), S_IMM (expect immediate word)
//   if_id_t         IF/ID pipeline register contents
//   has_imm()       tests the immediate-follows flag of an opcode word
package mznm_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic {
        S_WORD0 = 1'b0,
        S_IMM   = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] imm;
        logic [PC_W-1:0]    pc;
        logic               is32;
    } if_id_t;

    // An opcode word with its flag bit set is followed by one immediate word.
    function automatic logic has_imm(input logic [INSTR_W-1:0] word,
                                     input int                 flag_bit);
        return word[flag_bit];
    endfunction

endpackage

// File: rtl/fetch_perf_counter.sv
// Two free-running event counters for the fetch stage (delivered instructions, bubbles).
// Latency: count reflects an event on the posedge that follows it.
// Backpressure: none; increments are single-cycle strobes, counters wrap modulo 2^CNT_W.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset (clears both counters)
//   fetched_inc     strobe: an instruction is being written into IF/ID this cycle
//   bubble_inc      strobe: IF/ID is being written invalid on a non-stalled cycle
//   fetched_cnt     running count of delivered instructions
//   bubble_cnt      running count of bubble cycles
module fetch_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetched_inc,
    input  logic             bubble_inc,
    output logic [CNT_W-1:0] fetched_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);
    import mznm_pkg::*;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] fetched_q;
    logic [CNT_W-1:0] bubble_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q <= '0;
            bubble_q  <= '0;
        end else begin
            if (fetched_inc) begin
                fetched_q <= fetched_q + ONE;
            end
            if (bubble_inc) begin
                bubble_q <= bubble_q + ONE;
            end
        end
    end

    assign fetched_cnt = fetched_q;
    assign bubble_cnt  = bubble_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: reads 16-bit words at pc, assembles 16/32-bit instructions into IF/ID.
// Latency: 1 cycle word->IF/ID for 16-bit instructions, 2 cycles (one bubble) for 32-bit ones.
// Backpressure: stall freezes IF/ID and the FSM and raises pc_hold combinationally; flush wins over stall.
//
// Optional feature: define FETCH_PERF_CNT_EN to add the perf_fetched/perf_bubbles
// counters (and the CNT_W parameter); without it those ports do not exist.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   pc              current PC (the PC stage changes it on negedge clk)
//   imem_addr       instruction-memory word address = pc[IMEM_AW-1:0], combinational
//   imem_data       word at imem_addr, combinational read
//   stall, flush    hazard-unit hold / redirect discard
//   pc_hold         = stall; the PC stage decodes it as "keep the current PC"
//   if_id_*         IF/ID register: valid, opcode word, immediate word, opcode PC, is32
//   perf_fetched    (FETCH_PERF_CNT_EN) instructions delivered
//   perf_bubbles    (FETCH_PERF_CNT_EN) non-stalled cycles that left IF/ID invalid
module fetch_stage #(
    parameter int                           IMEM_AW      = 20,
    parameter int                           IMM_FLAG_BIT = 15,
    parameter logic [mznm_pkg::INSTR_W-1:0] NOP_INSTR    = mznm_pkg::NOP_INSTR
`ifdef FETCH_PERF_CNT_EN
    ,
    parameter int                           CNT_W        = 32
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [mznm_pkg::PC_W-1:0]    pc,
    output logic [IMEM_AW-1:0]           imem_addr,
    input  logic [mznm_pkg::INSTR_W-1:0] imem_data,
    input  logic                         stall,
    input  logic                         flush,
    output logic                         pc_hold,
    output logic                         if_id_valid,
    output logic [mznm_pkg::INSTR_W-1:0] if_id_instr,
    output logic [mznm_pkg::INSTR_W-1:0] if_id_imm,
    output logic [mznm_pkg::PC_W-1:0]    if_id_pc,
    output logic                         if_id_is32
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]             perf_fetched,
    output logic [CNT_W-1:0]             perf_bubbles
`endif
);
    import mznm_pkg::*;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fetch_state_t       state_q, state_d;
    logic [INSTR_W-1:0] word0_q, word0_d;   // opcode word waiting for its immediate
    logic [PC_W-1:0]    pc0_q,   pc0_d;     // PC of that opcode word
    if_id_t             ifid_q,  ifid_d;

    // Memory address is a plain truncation: upper pc bits only matter for
    // if_id_pc, and the instruction memory wraps modulo 2^IMEM_AW.
    assign imem_addr = pc[IMEM_AW-1:0];

    // The PC stage must see the hold in the same cycle the stall is raised,
    // otherwise it would step past the word that IF/ID is refusing.
    assign pc_hold = stall;

    // ------------------------------------------------------------------
    // Next-state / next IF/ID
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        word0_d = word0_q;
        pc0_d   = pc0_q;
        ifid_d  = ifid_q;

        if (flush) begin
            // Redirect: whatever is in flight (including a half-assembled
            // 32-bit instruction) belongs to the wrong path.
            ifid_d.valid = 1'b0;
            ifid_d.instr = NOP_INSTR;
            state_d      = S_WORD0;
            word0_d      = '0;
            pc0_d        = '0;
        end else if (!stall) begin
            case (state_q)
                S_WORD0: begin
                    if (has_imm(imem_data, IMM_FLAG_BIT)) begin
                        // First half of a 32-bit instruction: park it and
                        // emit a bubble while the immediate is fetched.
                        word0_d      = imem_data;
                        pc0_d        = pc;
                        ifid_d.valid = 1'b0;
                        state_d      = S_IMM;
                    end else begin
                        ifid_d.valid = 1'b1;
                        ifid_d.instr = imem_data;
                        ifid_d.imm   = '0;
                        ifid_d.pc    = pc;
                        ifid_d.is32  = 1'b0;
                    end
                end
                S_IMM: begin
                    // The second word is pure data; its flag bit is not
                    // interpreted here.
                    ifid_d.valid = 1'b1;
                    ifid_d.instr = word0_q;
                    ifid_d.imm   = imem_data;
                    ifid_d.pc    = pc0_q;
                    ifid_d.is32  = 1'b1;
                    state_d      = S_WORD0;
                end
                default: begin
                    state_d = S_WORD0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_WORD0;
            word0_q      <= '0;
            pc0_q        <= '0;
            ifid_q.valid <= 1'b0;
            ifid_q.instr <= NOP_INSTR;
            ifid_q.imm   <= '0;
            ifid_q.pc    <= '0;
            ifid_q.is32  <= 1'b0;
        end else begin
            state_q <= state_d;
            word0_q <= word0_d;
            pc0_q   <= pc0_d;
            ifid_q  <= ifid_d;
        end
    end

    assign if_id_valid = ifid_q.valid;
    assign if_id_instr = ifid_q.instr;
    assign if_id_imm   = ifid_q.imm;
    assign if_id_pc    = ifid_q.pc;
    assign if_id_is32  = ifid_q.is32;

`ifdef FETCH_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    // A delivery is only counted when normal operation writes a valid
    // instruction; a bubble is any non-stalled cycle that leaves IF/ID
    // invalid (including flush cycles, but not flush+stall).
    logic fetched_inc;
    logic bubble_inc;

    assign fetched_inc = !reset && !flush && !stall && ifid_d.valid;
    assign bubble_inc  = !reset && !stall && !ifid_d.valid;

    fetch_perf_counter #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk         (clk),
        .reset       (reset),
        .fetched_inc (fetched_inc),
        .bubble_inc  (bubble_inc),
        .fetched_cnt (perf_fetched),
        .bubble_cnt  (perf_bubbles)
    );
`endif

endmodule
